// File: rtl/npu_pkg.sv
// npu_pkg: shared types and sizing helpers for the NPU output stage.
//   drain_state_t : drain FSM states
//   acc_width()   : accumulator width produced by a simpleNPU of dimension n
package npu_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } drain_state_t;

    // simpleNPU accumulates N products of 8x8-bit operands: 16 bits plus
    // N-1 bits of carry growth.
    function automatic int acc_width(input int n);
        return 16 + n - 1;
    endfunction

endpackage

// File: rtl/npu_sat_shift.sv
// npu_sat_shift: combinational requantizer.
//   value : unsigned accumulator (ACC_W bits)
//   shift : logical right-shift amount (0..31; >= ACC_W yields 0)
//   data  : shifted value, clamped to all ones when it does not fit OUT_W
//   sat   : high when data was clamped
module npu_sat_shift #(
    parameter int ACC_W = 17,
    parameter int OUT_W = 8
) (
    input  logic [ACC_W-1:0] value,
    input  logic [4:0]       shift,
    output logic [OUT_W-1:0] data,
    output logic             sat
);

    logic [ACC_W-1:0] v;

    // A shift count at or beyond the operand width already yields zero.
    assign v = value >> shift;

    generate
        if (ACC_W > OUT_W) begin : g_sat
            assign sat  = |v[ACC_W-1:OUT_W];
            assign data = sat ? {OUT_W{1'b1}} : v[OUT_W-1:0];
        end else begin : g_nosat
            assign sat  = 1'b0;
            assign data = OUT_W'(v);
        end
    endgenerate

endmodule

// File: rtl/npu_result_drain.sv
// npu_result_drain: captures a finished N x N result matrix from simpleNPU,
// requantizes each element and streams it row-major over valid/ready.
//   clk, rst            : clock, synchronous active-high reset
//   res_in, res_valid   : result matrix (element i*N+j = C[i][j]) and strobe
//   shift               : requantization shift, captured with the matrix
//   busy                : a captured matrix is still draining
//   drop                : sticky, a matrix arrived while busy and was lost
//   m_valid/m_ready     : output handshake
//   m_data, m_sat       : requantized element and its saturation flag
//   m_index, m_last     : row-major index, high on the final element
module npu_result_drain
    import npu_pkg::*;
#(
    parameter int N     = 2,
    parameter int ACC_W = acc_width(N),
    parameter int OUT_W = 8,
    parameter int IDX_W = (N * N > 1) ? $clog2(N * N) : 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N*N-1:0][ACC_W-1:0]  res_in,
    input  logic                       res_valid,
    input  logic [4:0]                 shift,
    output logic                       busy,
    output logic                       drop,
    output logic                       m_valid,
    input  logic                       m_ready,
    output logic [OUT_W-1:0]           m_data,
    output logic                       m_sat,
    output logic [IDX_W-1:0]           m_index,
    output logic                       m_last
);

    localparam int              NN       = N * N;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NN - 1);

    drain_state_t               state_q, state_d;
    logic [IDX_W-1:0]           idx_q, idx_d;
    logic                       valid_q, valid_d;
    logic                       drop_q, drop_d;
    logic [OUT_W-1:0]           data_q;
    logic                       sat_q;
    logic                       last_q;
    logic [NN-1:0][ACC_W-1:0]   buf_q;
    logic [4:0]                 shift_q;

    logic                       hs;
    logic                       at_last;
    logic                       capture;
    logic                       load;
    logic [ACC_W-1:0]           sel_val;
    logic [4:0]                 sel_sh;
    logic [OUT_W-1:0]           rq_data;
    logic                       rq_sat;

    assign hs      = valid_q && m_ready;
    assign at_last = (idx_q == LAST_IDX);

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        valid_d = valid_q;
        drop_d  = drop_q;
        capture = 1'b0;
        load    = 1'b0;
        case (state_q)
            IDLE: begin
                if (res_valid) begin
                    capture = 1'b1;
                    load    = 1'b1;
                    state_d = STREAM;
                    idx_d   = '0;
                    valid_d = 1'b1;
                end
            end
            STREAM: begin
                if (hs && at_last) begin
                    // A matrix arriving on the final beat chains straight in.
                    if (res_valid) begin
                        capture = 1'b1;
                        load    = 1'b1;
                        idx_d   = '0;
                    end else begin
                        state_d = IDLE;
                        valid_d = 1'b0;
                    end
                end else begin
                    if (hs) begin
                        load  = 1'b1;
                        idx_d = idx_q + 1'b1;
                    end
                    if (res_valid) drop_d = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                valid_d = 1'b0;
            end
        endcase
    end

    // The single requantizer looks at the element that will be presented
    // next cycle, so outputs come straight from flops. On capture the
    // buffer is not written yet, hence the bypass from res_in.
    assign sel_val = capture ? res_in[0] : buf_q[idx_d];
    assign sel_sh  = capture ? shift     : shift_q;

    npu_sat_shift #(
        .ACC_W (ACC_W),
        .OUT_W (OUT_W)
    ) u_sat_shift (
        .value (sel_val),
        .shift (sel_sh),
        .data  (rq_data),
        .sat   (rq_sat)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            valid_q <= 1'b0;
            drop_q  <= 1'b0;
            data_q  <= '0;
            sat_q   <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            valid_q <= valid_d;
            drop_q  <= drop_d;
            if (load) begin
                data_q <= rq_data;
                sat_q  <= rq_sat;
                last_q <= (idx_d == LAST_IDX);
            end
        end
    end

    // Capture buffer carries no reset; it is only read after a capture.
    always_ff @(posedge clk) begin
        if (capture) begin
            buf_q   <= res_in;
            shift_q <= shift;
        end
    end

    assign busy    = (state_q == STREAM);
    assign drop    = drop_q;
    assign m_valid = valid_q;
    assign m_data  = data_q;
    assign m_sat   = sat_q;
    assign m_index = idx_q;
    assign m_last  = last_q;

endmodule
